// File: rtl/operand_sequencer.sv
// operand_sequencer
// Produces a stream of operand pairs (a, b) for driving an arithmetic block
// under test. Three pair sources are available:
//   directed    - a fixed table of eight corner-case pairs
//   random      - a Galois LFSR; a is the upper half, b the lower half
//   exhaustive  - pair i is (i mod 2^WIDTH, (i / 2^WIDTH) mod 2^WIDTH)
//
// Handshake (out_valid / out_ready):
//   A pair is transferred on every rising edge where out_valid && out_ready.
//   While out_valid is high and out_ready is low, a, b and index hold their
//   values. out_valid never drops without a transfer, except on reset.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high; overrides every other input
//   start        begins a run; only looked at in IDLE
//   mode         00 directed, 01 random, 10 exhaustive, 11 as directed
//   num_vectors  requested pair count
//   seed         LFSR seed for random mode (0 selects DEF_SEED)
//   out_valid    a/b/index hold a pair
//   out_ready    downstream accepts the pair
//   a, b         operands
//   index        zero-based ordinal of the presented pair
//   busy         high while in RUN
//   done         one-cycle pulse when a run completes
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE)
module operand_sequencer #(
  parameter int                  WIDTH    = 8,
  parameter logic [2*WIDTH-1:0]  POLY     = (2*WIDTH)'(16'hB400),
  parameter logic [2*WIDTH-1:0]  DEF_SEED = (2*WIDTH)'(16'hACE1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [15:0]        num_vectors,
  input  logic [2*WIDTH-1:0] seed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [15:0]        index,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam int LW = 2 * WIDTH;

  // Largest useful exhaustive count. When the pair space exceeds the 16-bit
  // counter range the requested count can never be larger, so no clamp.
  localparam logic [15:0] EXH_LIMIT = (LW >= 16) ? 16'hFFFF : 16'(1 << LW);

  localparam logic [1:0] M_DIR  = 2'b00;
  localparam logic [1:0] M_RAND = 2'b01;
  localparam logic [1:0] M_EXH  = 2'b10;

  localparam logic [7:0] DIR_A [8] = '{8'd5, 8'd10, 8'd15, 8'd0, 8'd255, 8'd128, 8'd1, 8'd127};
  localparam logic [7:0] DIR_B [8] = '{8'd3, 8'd4, 8'd2, 8'd100, 8'd1, 8'd128, 8'd255, 8'd129};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [15:0]     total;
  logic [LW-1:0]   lfsr;

  logic [1:0]      mode_eff;
  logic [LW-1:0]   seed_eff;
  logic [15:0]     start_total;
  logic [LW-1:0]   first_pair;
  logic [LW-1:0]   lfsr_next;
  logic [15:0]     idx_next;
  logic [LW-1:0]   next_pair;
  logic            last_xfer;

  // One Galois step: shift right, fold in the feedback mask when a 1 falls out.
  function automatic logic [LW-1:0] galois_step(input logic [LW-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Pair for ordinal i; l is the LFSR state that belongs to that ordinal.
  function automatic logic [LW-1:0] pair_for(input logic [1:0] m,
                                             input logic [15:0] i,
                                             input logic [LW-1:0] l);
    case (m)
      M_RAND:  return l;
      M_EXH:   return {WIDTH'(i), WIDTH'(i >> WIDTH)};
      default: return {WIDTH'(DIR_A[i[2:0]]), WIDTH'(DIR_B[i[2:0]])};
    endcase
  endfunction

  always_comb begin
    mode_eff = (mode == 2'b11) ? M_DIR : mode;
    seed_eff = (seed == '0) ? DEF_SEED : seed;
    case (mode_eff)
      M_RAND:  start_total = num_vectors;
      M_EXH:   start_total = (num_vectors > EXH_LIMIT) ? EXH_LIMIT : num_vectors;
      default: start_total = (num_vectors > 16'd8) ? 16'd8 : num_vectors;
    endcase
    first_pair = pair_for(mode_eff, 16'd0, seed_eff);
    lfsr_next  = galois_step(lfsr);
    idx_next   = index + 16'd1;
    next_pair  = pair_for(mode_q, idx_next, lfsr_next);
    // total is at least 1 whenever RUN is entered, so total-1 never wraps.
    last_xfer  = (index == total - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_q    <= M_DIR;
      total     <= 16'd0;
      lfsr      <= DEF_SEED;
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      index     <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode_eff;
            total  <= start_total;
            lfsr   <= seed_eff;
            index  <= 16'd0;
            if (start_total == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              {a, b}    <= first_pair;
            end
          end
        end
        S_RUN: begin
          if (out_valid && out_ready) begin
            // The LFSR advances on every transfer, including the last one.
            lfsr <= lfsr_next;
            if (last_xfer) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              index  <= idx_next;
              {a, b} <= next_pair;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer (WIDTH=8 defaults).
// Inputs are driven 2 time units after each rising edge; outputs are sampled
// on the falling edge. Expected pairs of a run are queued when the run is
// started and popped by the monitor on each observed transfer.
module tb_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] num_vectors;
  logic [15:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] index;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  operand_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .num_vectors (num_vectors),
    .seed        (seed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a           (a),
    .b           (b),
    .index       (index),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int total_n = 0;
  int bad_n   = 0;
  int run_id  = 0;

  int          done_cnt;
  int          done_cyc;
  int          xfer_cnt;
  int          last_xfer_cyc;
  bit          valid_seen;
  int          first_valid_cyc;
  bit          held_valid = 1'b0;
  logic [31:0] held;
  logic [15:0] got [0:511];

  localparam logic [7:0] TA [8] = '{8'd5, 8'd10, 8'd15, 8'd0, 8'd255, 8'd128, 8'd1, 8'd127};
  localparam logic [7:0] TB [8] = '{8'd3, 8'd4, 8'd2, 8'd100, 8'd1, 8'd128, 8'd255, 8'd129};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL run%0d %s: got %0h want %0h", run_id, name, act, exp);
    end
  endtask

  function automatic logic [15:0] gstep(input logic [15:0] s);
    logic [15:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 16'hB400;
    return t;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && !valid_seen) begin
        valid_seen      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (held_valid) check("hold_stable", {a, b, index}, held);
      held_valid = out_valid && !out_ready;
      held       = {a, b, index};
      if (out_valid && out_ready) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (index < 16'd512) got[index[8:0]] = {a, b};
        if (exp_q.size() == 0) begin
          check("extra_transfer", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("pair", {a, b, index}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    done_cnt   = 0;
    done_cyc   = -1;
    xfer_cnt   = 0;
    valid_seen = 1'b0;
    last_xfer_cyc   = -1;
    first_valid_cyc = -1;
  endtask

  // rmode: 0 always ready, 1 random ready (and random start pulses),
  //        2 ready low for three cycles while pair 1 is presented
  task automatic run_case(input logic [1:0] m, input logic [15:0] nv, input logic [15:0] sd,
                          input int rmode, input int exp_total);
    logic [15:0] l;
    logic [15:0] iv;
    int          start_cyc;
    run_id++;
    l = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int i = 0; i < exp_total; i++) begin
      iv = 16'(i);
      case (m)
        2'b01: begin
          exp_q.push_back({l, iv});
          l = gstep(l);
        end
        2'b10:   exp_q.push_back({iv[7:0], iv[15:8], iv});
        default: exp_q.push_back({TA[i], TB[i], iv});
      endcase
    end
    clear_stats();
    out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b1; mode = m; num_vectors = nv; seed = sd;
    start_cyc = cyc + 1;
    @(posedge clk); #2;
    start = 1'b0;
    mode = 2'($urandom); num_vectors = 16'($urandom); seed = 16'($urandom);
    check("busy_after_start", {31'd0, busy}, (exp_total > 0) ? 32'd1 : 32'd0);
    if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
    if (rmode == 2) out_ready = 1'b1;
    for (int j = 1; j <= exp_total * 8 + 20; j++) begin
      @(posedge clk); #2;
      if (done_cnt > 0) break;
      case (rmode)
        1: begin
          out_ready = 1'($urandom_range(0, 1));
          start     = 1'($urandom_range(0, 1));
        end
        2: begin
          out_ready = (j < 1 || j > 3);
          if (j == 2) check("bp_pair1", {a, b, index}, {8'd10, 8'd4, 16'd1});
        end
        default: out_ready = 1'b1;
      endcase
    end
    start = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("done_count", 32'(done_cnt), 32'd1);
    check("xfer_count", 32'(xfer_cnt), 32'(exp_total));
    check("queue_left", 32'(exp_q.size()), 32'd0);
    check("idle_after", {29'd0, busy, state_dbg}, 32'd0);
    if (exp_total == 0) begin
      check("no_valid", {31'd0, valid_seen}, 32'd0);
      check("done_after_start", 32'(done_cyc), 32'(start_cyc));
    end else begin
      check("first_valid_cyc", 32'(first_valid_cyc), 32'(start_cyc));
      check("done_after_last", 32'(done_cyc), 32'(last_xfer_cyc + 1));
      if (rmode == 0)
        check("back_to_back", 32'(last_xfer_cyc - first_valid_cyc), 32'(exp_total - 1));
    end
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  m;
    logic [15:0] nv;
    logic [15:0] sd;
    int          rmode;
    int          exp_total;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{m: 2'b00, nv: 16'd10, sd: 16'h0000, rmode: 0, exp_total: 8};
    vecs[1] = '{m: 2'b00, nv: 16'd3,  sd: 16'h0000, rmode: 1, exp_total: 3};
    vecs[2] = '{m: 2'b11, nv: 16'd5,  sd: 16'h0000, rmode: 0, exp_total: 5};
    vecs[3] = '{m: 2'b01, nv: 16'd40, sd: 16'h1234, rmode: 1, exp_total: 40};
    vecs[4] = '{m: 2'b00, nv: 16'd0,  sd: 16'h0000, rmode: 0, exp_total: 0};
    vecs[5] = '{m: 2'b10, nv: 16'd20, sd: 16'h0000, rmode: 0, exp_total: 20};
    vecs[6] = '{m: 2'b01, nv: 16'd1,  sd: 16'hFFFF, rmode: 0, exp_total: 1};

    reset = 1'b1; start = 1'b0; mode = 2'b00; num_vectors = 16'd0;
    seed = 16'd0; out_ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #2;
    start = 1'b1;   // must lose to reset
    @(posedge clk); #2;
    check("reset_outputs", {out_valid, busy, done, a, b, index}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;

    for (int k = 0; k < 7; k++)
      run_case(vecs[k].m, vecs[k].nv, vecs[k].sd, vecs[k].rmode, vecs[k].exp_total);

    // Random with zero seed: default seed and one Galois step.
    run_case(2'b01, 16'd4, 16'd0, 0, 4);
    check("rand_pair0", {16'd0, got[0]}, 32'h0000ACE1);
    check("rand_pair1", {16'd0, got[1]}, 32'h0000E270);

    // Exhaustive wrap of a into b.
    run_case(2'b10, 16'd300, 16'd0, 1, 300);
    check("exh_pair255", {16'd0, got[255]}, 32'h0000FF00);
    check("exh_pair256", {16'd0, got[256]}, 32'h00000001);
    check("exh_pair299", {16'd0, got[299]}, 32'h00002B01);

    // Backpressure on pair 1.
    run_case(2'b00, 16'd10, 16'd0, 2, 8);

    // Reset in the middle of a run.
    run_id++;
    clear_stats();
    for (int i = 0; i < 3; i++) exp_q.push_back({TA[i], TB[i], 16'(i)});
    out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b1; mode = 2'b00; num_vectors = 16'd8; seed = 16'd0;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    check("pre_reset_index", {16'd0, index}, 32'd3);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("abort_outputs", {out_valid, busy, done, a, b, index}, 32'd0);
    check("abort_state", {30'd0, state_dbg}, 32'd0);
    repeat (4) begin @(posedge clk); #2; end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_case(2'b00, 16'd10, 16'd0, 0, 8);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter POLY, default 16'hB400, Galois LFSR feedback mask, 2*WIDTH bits.
REQ-003 SHALL have parameter DEF_SEED, default 16'hACE1, substitute seed when seed input is zero.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begins a run; honoured only in IDLE.
REQ-007 SHALL have port mode  input  2  00 directed, 01 random, 10 exhaustive, 11 treated as directed.
REQ-008 SHALL have port num_vectors  input  16  requested vector count.
REQ-009 SHALL have port seed  input  2*WIDTH  LFSR seed for random mode.
REQ-010 SHALL have port out_valid  output  1  operand pair a/b is valid.
REQ-011 SHALL have port out_ready  input  1  downstream DUT driver accepts pair.
REQ-012 SHALL have port a  output  WIDTH  operand A.
REQ-013 SHALL have port b  output  WIDTH  operand B.
REQ-014 SHALL have port index  output  16  zero-based ordinal of the presented pair.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE: on start, SHALL latch mode, num_vectors, seed and compute total; next state RUN, or DONE if total==0.
REQ-019 total SHALL be min(8,num_vectors) directed; num_vectors random; min(num_vectors, 2^(2*WIDTH)) exhaustive.
REQ-020 First pair SHALL appear with out_valid=1 the cycle after start is sampled; index=0.
REQ-021 Transfer SHALL occur in any cycle with out_valid && out_ready; index increments by 1 per transfer.
REQ-022 While out_valid && !out_ready, a, b, index SHALL hold stable.
REQ-023 On the transfer with index==total-1, SHALL go to DONE; out_valid deasserts next cycle.
REQ-024 DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
REQ-025 start in RUN or DONE SHALL be ignored; config inputs SHALL be ignored outside the start cycle.
REQ-026 Directed: pair i SHALL be a from {5,10,15,0,255,128,1,127}, b from {3,4,2,100,1,128,255,129}, truncated to WIDTH.
REQ-027 Random: LFSR SHALL load seed (DEF_SEED if seed==0) at start; a=lfsr[2W-1:W], b=lfsr[W-1:0].
REQ-028 Random: LFSR SHALL advance one Galois step per transfer: shift right, XOR POLY if shifted-out bit was 1.
REQ-029 Exhaustive: pair i SHALL be a = i mod 2^WIDTH, b = (i / 2^WIDTH) mod 2^WIDTH.
REQ-030 Index counter SHALL not wrap within a run; total <= 65535 by construction.
REQ-031 busy SHALL equal (state==RUN).

Reset
REQ-032 reset SHALL take priority over all inputs including start.
REQ-033 On reset: state IDLE, out_valid=0, busy=0, done=0, a=0, b=0, index=0, LFSR=DEF_SEED.
REQ-034 reset asserted mid-run SHALL abort without a done pulse; next start after release runs normally.

Verification
REQ-035 Directed: mode=00, num_vectors=10, out_ready=1 -> 8 pairs (5,3)...(127,129), index 0..7 consecutive cycles, done one cycle after last.
REQ-036 Backpressure: mode=00, out_ready low cycles 2-4 -> pair (10,4) held stable with index=1 until accepted; no pair lost or duplicated.
REQ-037 Exhaustive: mode=10, num_vectors=300 -> pair 255=(255,0), pair 256=(0,1), pair 299=(43,1); 300 transfers then done.
REQ-038 Random: seed=0 -> first pair (8'hAC,8'hE1); second pair equals one Galois step of 16'hACE1 with POLY 16'hB400 = 16'hE270 -> (8'hE2,8'h70).
REQ-039 Zero count: num_vectors=0, start -> out_valid never asserts, done pulses cycle after start.
REQ-040 Reset mid-run: reset during pair 3 -> all outputs zero next cycle, no done; new start restarts at index 0.
